add_round_key_seq: RTL and testbench
====================================

# add_round_key_seq

Sequential, parametrised AES AddRoundKey stage. It holds a bank of round keys, accepts one state block per handshake with a round index, and XORs the block with the selected round key over `BLOCK_BYTES/LANES` beats. It returns the result on a valid/ready output port. It sits between the key-expansion writer and the round datapath, replacing the purely combinational 16-byte XOR.

## Interface

- `BLOCK_BYTES`, default 16: state/key size in bytes. Must be a multiple of `LANES`.
- `LANES`, default 4: bytes XORed per beat. `B = BLOCK_BYTES/LANES` beats per block.
- `NUM_KEYS`, default 11: round-key bank depth. `KW = max(1, $clog2(NUM_KEYS))`.
- `clk`, in, 1: the single clock. All logic is rising-edge.
- `rst`, in, 1: synchronous, active-high reset.
- `key_we`, in, 1: write enable for the key bank.
- `key_waddr`, in, KW: key bank index to write.
- `key_wdata`, in, 8*BLOCK_BYTES: round key. Byte i is bits [8i+7:8i].
- `in_valid`, in, 1: input block offered.
- `in_ready`, out, 1: block accepted on an edge when `in_valid && in_ready`.
- `in_state`, in, 8*BLOCK_BYTES: state block. Same byte mapping as the key.
- `in_round`, in, KW: key bank index to apply.
- `out_valid`, out, 1: result available.
- `out_ready`, in, 1: result consumed on an edge when `out_valid && out_ready`.
- `out_state`, out, 8*BLOCK_BYTES: state XOR key.
- `out_round`, out, KW: round index echoed from input.
- `out_err`, out, 1: high with the result when `in_round >= NUM_KEYS`.

## Operation

- Key bank: `NUM_KEYS` registers. Written on an edge with `key_we`. Writes with `key_waddr >= NUM_KEYS` are ignored. Writes are allowed in every FSM state.
- FSM states: IDLE, XOR, HOLD.
- IDLE:
  - `in_ready = 1`.
  - On accept: capture `in_state` into the work register and `in_round` into the round register.
  - Copy `key[in_round]` into the working key register. If the index is out of range, load zero and set the error flag.
  - Set the beat counter to 0 and go to XOR.
- XOR:
  - `in_ready = 0`.
  - Each edge, replace work bytes `[beat*LANES .. beat*LANES+LANES-1]` with themselves XOR the matching working-key bytes.
  - The beat counter increments. On the edge that processes beat B-1, the counter wraps to 0, `out_valid` sets and the FSM goes to HOLD.
- HOLD:
  - `out_valid = 1`. `out_state`, `out_round` and `out_err` stay stable.
  - On an `out_ready` edge, `out_valid` clears and the FSM goes to IDLE.
  - `out_ready` low stalls the block indefinitely.
- The key snapshot is taken at accept. Later `key_we` writes, even to the same index, do not affect the block in flight.
- Same-edge accept and `key_we` to the same index: the block uses the old key and the bank takes the new one.
- Out-of-range round: the block passes through unchanged with `out_err = 1`. No other side effect.
- `out_state` is the work register. Its value is architecturally defined only while `out_valid = 1`.

## Timing

- Reset values:
  - FSM = IDLE, beat counter = 0.
  - `out_valid = 0`, `out_state = 0`, `out_round = 0`, `out_err = 0`.
  - Key bank cleared to all zero.
  - `in_ready` is 0 during the reset cycle and 1 from the first cycle after reset deasserts.
- Reset mid-block, in XOR or HOLD: the block is discarded and no output is produced. The key bank is cleared.
- Latency: if accepted at edge N, `out_valid` is first high after edge N+B. Example: LANES=16 gives one edge; default parameters give 4.
- Throughput with `out_ready` tied high: one block per B+2 cycles, made up of accept, B beats, and one HOLD cycle.
- `in_ready` depends only on the FSM state. It has no combinational path from `in_valid` or `out_ready`.

## Test plan

- Basic XOR:
  - Stimulus: write key 0 with bytes 0C 0D 0E 0F repeated ×4. Offer a state with bytes 00..0F, round 0.
  - Response: `out_state` bytes are 0C 0C 0C 0C 08 08 08 08 04 04 04 04 00 00 00 00. `out_round = 0`, `out_err = 0`, and `out_valid` rises 4 edges after accept.
- Second pattern in another slot:
  - Stimulus: write key 10 with bytes 5C..5F ×4. Offer a state with bytes 50..5F, round 10.
  - Response: the same 0C..00 pattern as above, with `out_round = 10`.
- Back-pressure:
  - Stimulus: hold `out_ready = 0` for 5 cycles after `out_valid` rises.
  - Response: `out_valid`, `out_state` and `out_round` stay stable, and `in_ready` stays 0. After one `out_ready` edge, `out_valid = 0` and `in_ready = 1`.
- Key hazard:
  - Stimulus: accept a round-3 block in the same edge as a write to key 3, then issue another key-3 write during XOR.
  - Response: the result uses the pre-write key. A following round-3 block uses the last written key.
- Error and range:
  - Stimulus: offer `in_round = 11` with state 00..0F.
  - Response: `out_state` = 00..0F unchanged and `out_err = 1`. Separately, a key write to index 12 (only when `KW` ≥ 4) leaves the bank unchanged.
- Reset and parameters:
  - Stimulus: assert `rst` during beat 2 of a block.
  - Response: no `out_valid`, all outputs at zero, and a fresh block completes correctly afterwards.
  - Repeat the basic XOR scenario with LANES=1 (16 beats) and LANES=16 (1 beat).

Source files
------------

// File: rtl/add_round_key_seq.sv
// Multi-beat AES AddRoundKey: a key bank plus a work register that is XORed
// LANES bytes per cycle, with valid/ready handshakes on both sides.

module ark_lane (
  input  logic [7:0] s,
  input  logic [7:0] k,
  output logic [7:0] y
);
  assign y = s ^ k;
endmodule

module add_round_key_seq #(
  parameter  int BLOCK_BYTES = 16,
  parameter  int LANES       = 4,
  parameter  int NUM_KEYS    = 11,
  localparam int KW          = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_we,
  input  logic [KW-1:0]            key_waddr,
  input  logic [8*BLOCK_BYTES-1:0] key_wdata,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [8*BLOCK_BYTES-1:0] in_state,
  input  logic [KW-1:0]            in_round,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [8*BLOCK_BYTES-1:0] out_state,
  output logic [KW-1:0]            out_round,
  output logic                     out_err
);
  localparam int NB    = BLOCK_BYTES / LANES;
  localparam int BW    = (NB > 1) ? $clog2(NB) : 1;
  localparam int BLK_W = 8 * BLOCK_BYTES;

  localparam logic [BW-1:0] LAST = BW'(NB - 1);
  localparam logic [KW:0]   NK   = (KW + 1)'(NUM_KEYS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XOR  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  // Beat-major view of a block: [beat][lane][byte], bit-identical to the flat bus.
  typedef logic [NB-1:0][LANES-1:0][7:0] blk_t;

  typedef struct packed {
    logic [KW-1:0] round;
    logic          err;
  } tag_t;

  logic [1:0]                     state_q;
  logic [BW-1:0]                  beat_q;
  blk_t                           work_q;
  blk_t                           wkey_q;
  tag_t                           tag_q;
  logic                           out_valid_q;
  logic [NUM_KEYS-1:0][BLK_W-1:0] key_bank;

  logic [LANES-1:0][7:0] cur_s, cur_k, lane_y;
  logic                  in_rng, wr_rng;

  assign in_rng = {1'b0, in_round}  < NK;
  assign wr_rng = {1'b0, key_waddr} < NK;

  // Ready is a pure function of state (and reset), never of the handshakes.
  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign out_state = work_q;
  assign out_round = tag_q.round;
  assign out_err   = tag_q.err;

  always_comb begin
    cur_s = '0;
    cur_k = '0;
    for (int b = 0; b < NB; b++) begin
      if (beat_q == BW'(b)) begin
        cur_s = work_q[b];
        cur_k = wkey_q[b];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    ark_lane u_lane (
      .s (cur_s[l]),
      .k (cur_k[l]),
      .y (lane_y[l])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      work_q      <= '0;
      wkey_q      <= '0;
      tag_q       <= '0;
      out_valid_q <= 1'b0;
      key_bank    <= '0;
    end else begin
      // The snapshot below reads the pre-edge bank, so a same-edge write
      // to the selected index only affects later blocks.
      if (key_we && wr_rng)
        key_bank[key_waddr] <= key_wdata;

      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            work_q      <= in_state;
            tag_q.round <= in_round;
            tag_q.err   <= !in_rng;
            wkey_q      <= in_rng ? blk_t'(key_bank[in_round]) : '0;
            beat_q      <= '0;
            state_q     <= S_XOR;
          end
        end
        S_XOR: begin
          for (int b = 0; b < NB; b++)
            if (beat_q == BW'(b)) work_q[b] <= lane_y;
          if (beat_q == LAST) begin
            beat_q      <= '0;
            out_valid_q <= 1'b1;
            state_q     <= S_HOLD;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_add_round_key_seq.sv
// Bench for add_round_key_seq: directed scenarios plus random blocks on three
// lane widths, checked against a plain XOR-with-key-table model.
module tb_add_round_key_seq;
  localparam int NK = 11;
  localparam int KW = 4;

  localparam logic [127:0] S0    = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] K0    = 128'h0F0E0D0C0F0E0D0C0F0E0D0C0F0E0D0C;
  localparam logic [127:0] S10   = 128'h5F5E5D5C5B5A59585756555453525150;
  localparam logic [127:0] K10   = 128'h5F5E5D5C5F5E5D5C5F5E5D5C5F5E5D5C;
  localparam logic [127:0] XPECT = 128'h0000000004040404080808080C0C0C0C;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          key_we = 1'b0;
  logic [KW-1:0] key_waddr = '0;
  logic [127:0]  key_wdata = '0;
  logic [127:0]  in_state = '0;
  logic [KW-1:0] in_round = '0;
  logic [2:0]    in_valid = '0, out_ready = '0;
  logic [2:0]    in_ready, out_valid, out_err;
  logic [127:0]  o_state [3];
  logic [KW-1:0] o_round [3];

  int errors = 0;
  int checks = 0;
  int beats [3] = '{4, 16, 1};
  logic [127:0] mkey [NK];

  always #5 clk = ~clk;

  add_round_key_seq #(.BLOCK_BYTES(16), .LANES(4), .NUM_KEYS(NK)) dut0 (
    .clk(clk), .rst(rst), .key_we(key_we), .key_waddr(key_waddr), .key_wdata(key_wdata),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_state(in_state), .in_round(in_round),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_state(o_state[0]),
    .out_round(o_round[0]), .out_err(out_err[0]));

  add_round_key_seq #(.BLOCK_BYTES(16), .LANES(1), .NUM_KEYS(NK)) dut1 (
    .clk(clk), .rst(rst), .key_we(key_we), .key_waddr(key_waddr), .key_wdata(key_wdata),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_state(in_state), .in_round(in_round),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_state(o_state[1]),
    .out_round(o_round[1]), .out_err(out_err[1]));

  add_round_key_seq #(.BLOCK_BYTES(16), .LANES(16), .NUM_KEYS(NK)) dut2 (
    .clk(clk), .rst(rst), .key_we(key_we), .key_waddr(key_waddr), .key_wdata(key_wdata),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_state(in_state), .in_round(in_round),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_state(o_state[2]),
    .out_round(o_round[2]), .out_err(out_err[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wr_key(input int a, input logic [127:0] d);
    key_we = 1'b1; key_waddr = KW'(a); key_wdata = d;
    tick();
    key_we = 1'b0;
    if (a < NK) mkey[a] = d;
  endtask

  // Offers one block; optionally writes key[r] on the accepting edge.
  task automatic accept(input int d, input logic [127:0] s, input int r,
                        input logic kw, input logic [127:0] kd,
                        output logic [127:0] e_s, output logic e_err);
    int n;
    in_state = s; in_round = KW'(r); in_valid[d] = 1'b1;
    n = 0;
    while (!in_ready[d] && n < 50) begin tick(); n++; end
    chk("accept_ready", in_ready[d], 1);
    e_s   = (r < NK) ? (s ^ mkey[r]) : s;
    e_err = (r >= NK);
    if (kw) begin key_we = 1'b1; key_waddr = KW'(r); key_wdata = kd; end
    tick();
    in_valid[d] = 1'b0;
    key_we = 1'b0;
    if (kw && r < NK) mkey[r] = kd;
  endtask

  task automatic collect(input int d, input logic [127:0] e_s, input int e_r,
                         input logic e_err, input int e_lat, input int stall);
    int lat;
    lat = 0;
    while (!out_valid[d] && lat < 64) begin tick(); lat++; end
    chk("latency", lat, e_lat);
    chk("out_state", o_state[d], e_s);
    chk("out_round", o_round[d], e_r);
    chk("out_err", out_err[d], e_err);
    for (int k = 0; k < stall; k++) begin
      tick();
      chk("stall_valid", out_valid[d], 1);
      chk("stall_state", o_state[d], e_s);
      chk("stall_round", o_round[d], e_r);
      chk("stall_in_ready", in_ready[d], 0);
    end
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
    chk("post_valid", out_valid[d], 0);
    chk("post_in_ready", in_ready[d], 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] es, s;
    logic         ee;
    int           acc, d, r;

    for (int i = 0; i < NK; i++) mkey[i] = '0;

    // Reset state
    tick(); tick();
    chk("rst_in_ready", in_ready, 3'b000);
    chk("rst_out_valid", out_valid, 3'b000);
    chk("rst_out_state", o_state[0], 0);
    chk("rst_out_round", o_round[0], 0);
    chk("rst_out_err", out_err, 3'b000);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 3'b111);

    // Basic XOR and second slot
    wr_key(0, K0);
    accept(0, S0, 0, 1'b0, '0, es, ee);
    collect(0, XPECT, 0, 1'b0, 4, 0);
    wr_key(10, K10);
    accept(0, S10, 10, 1'b0, '0, es, ee);
    collect(0, XPECT, 10, 1'b0, 4, 0);

    // Back-pressure
    wr_key(5, rnd128());
    s = rnd128();
    accept(0, s, 5, 1'b0, '0, es, ee);
    collect(0, es, 5, ee, 4, 5);

    // Key hazard: same-edge write, then a write during XOR
    wr_key(3, rnd128());
    s = rnd128();
    accept(0, s, 3, 1'b1, rnd128(), es, ee);
    wr_key(3, rnd128());
    collect(0, es, 3, 1'b0, 3, 0);
    s = rnd128();
    accept(0, s, 3, 1'b0, '0, es, ee);
    collect(0, es, 3, 1'b0, 4, 0);

    // Out-of-range round and ignored write
    accept(0, S0, 11, 1'b0, '0, es, ee);
    collect(0, S0, 11, 1'b1, 4, 0);
    wr_key(12, rnd128());
    for (int i = 0; i < NK; i++) begin
      s = rnd128();
      accept(0, s, i, 1'b0, '0, es, ee);
      collect(0, es, i, 1'b0, 4, 0);
    end

    // Throughput with out_ready tied high: one block every 6 cycles
    acc = 0;
    out_ready[0] = 1'b1; in_valid[0] = 1'b1; in_round = '0; in_state = S0;
    for (int i = 0; i < 60; i++) begin
      if (in_ready[0]) acc++;
      tick();
    end
    in_valid[0] = 1'b0; out_ready[0] = 1'b0;
    chk("throughput", acc, 10);
    for (int i = 0; i < 10 && !in_ready[0]; i++) tick();

    // Reset during beat 2
    accept(0, S0, 0, 1'b0, '0, es, ee);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("midrst_out_valid", out_valid[0], 0);
    chk("midrst_out_state", o_state[0], 0);
    chk("midrst_out_round", o_round[0], 0);
    chk("midrst_out_err", out_err[0], 0);
    chk("midrst_in_ready", in_ready[0], 0);
    rst = 1'b0;
    for (int i = 0; i < NK; i++) mkey[i] = '0;
    #1;
    chk("midrst_ready_after", in_ready[0], 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midrst_no_output", out_valid[0], 0);
    end
    accept(0, S0, 0, 1'b0, '0, es, ee);
    collect(0, S0, 0, 1'b0, 4, 0);
    wr_key(0, K0);
    accept(0, S0, 0, 1'b0, '0, es, ee);
    collect(0, XPECT, 0, 1'b0, 4, 0);

    // Other lane widths
    accept(1, S0, 0, 1'b0, '0, es, ee);
    collect(1, XPECT, 0, 1'b0, 16, 0);
    accept(2, S0, 0, 1'b0, '0, es, ee);
    collect(2, XPECT, 0, 1'b0, 1, 0);

    // Random blocks across all three instances
    for (int it = 0; it < 40; it++) begin
      d = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) wr_key($urandom_range(0, 12), rnd128());
      r = $urandom_range(0, 12);
      s = rnd128();
      accept(d, s, r, 1'($urandom_range(0, 1)), rnd128(), es, ee);
      collect(d, es, r, ee, beats[d], $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
